// File: rtl/pad_in_filter.sv
// pad_in_filter: synchronizes an asynchronous pad level into clk_i and optionally
// debounces it, producing a registered level plus single-cycle edge pulses.
//
// Optional feature: define PAD_IN_FILTER_EDGE_CNT_EN to add a saturating 16-bit
// counter of rise_o/fall_o pulses (ports edge_cnt_clr_i / edge_cnt_o).
//
// Parameters:
//   CntWidth        width of the debounce counter and of filter_thresh_i
// Ports:
//   clk_i           clock, all state in this domain
//   rst_ni          asynchronous active-low reset
//   pad_in_i        raw pad level, asynchronous to clk_i
//   filter_en_i     1 = debounce active, 0 = bypass (synchronized level only)
//   filter_thresh_i consecutive cycles a new level must persist before acceptance
//   edge_cnt_clr_i  (macro only) clear the edge counter, wins over increment
//   edge_cnt_o      (macro only) saturating count of rise/fall pulses
//   data_o          filtered, synchronized level (registered)
//   rise_o          one-cycle pulse when data_o goes 0->1 (registered)
//   fall_o          one-cycle pulse when data_o goes 1->0 (registered)
module pad_in_filter #(
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pad_in_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] filter_thresh_i,
`ifdef PAD_IN_FILTER_EDGE_CNT_EN
    input  logic                edge_cnt_clr_i,
    output logic [15:0]         edge_cnt_o,
`endif
    output logic                data_o,
    output logic                rise_o,
    output logic                fall_o
);

    typedef enum logic [0:0] {StStable, StQualify} state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync_q;
    logic                data_q, data_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic [CntWidth-1:0] cnt_inc;
    logic [CntWidth-1:0] cnt_run;
    logic                diff;
    logic                accept;

    // Two-flop synchronizer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= pad_in_i;
            sync_q  <= sync1_q;
        end
    end

    // cnt_run is the number of consecutive differing cycles including the current
    // one, so a threshold of N accepts N cycles after sync first differs and a
    // threshold of 0 or 1 matches bypass latency.
    always_comb begin
        cnt_inc = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);
        cnt_run = (state_q == StStable) ? CntWidth'(1) : cnt_inc;
        diff    = (sync_q != data_q);
        accept  = diff && (cnt_run >= filter_thresh_i);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StStable;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stay qualifying only while enabled, differing and not yet accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStable: begin
                if (filter_en_i && diff && !accept) begin
                    state_d = StQualify;
                end
            end
            StQualify: begin
                if (!filter_en_i || !diff || accept) begin
                    state_d = StStable;
                end
            end
            default: state_d = StStable;
        endcase
    end

    // FSM outputs / datapath next state.
    always_comb begin
        cnt_d  = '0;
        data_d = data_q;
        if (!filter_en_i) begin
            data_d = sync_q;
        end else if (accept) begin
            data_d = sync_q;
        end else if (diff) begin
            cnt_d = cnt_run;
        end
        rise_d = data_d & ~data_q;
        fall_d = ~data_d & data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef PAD_IN_FILTER_EDGE_CNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (edge_cnt_clr_i) begin
            edge_cnt_d = '0;
        end else if ((rise_q || fall_q) && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter: directed pad stimulus, expected edge
// events queued with the cycle they must appear, and a monitor that pops and
// compares on every rise_o/fall_o pulse.
module tb_pad_in_filter;

    logic       clk;
    logic       rst_n;
    logic       pad;
    logic       en;
    logic [7:0] thresh;
    logic       data_o;
    logic       rise_o;
    logic       fall_o;
`ifdef PAD_IN_FILTER_EDGE_CNT_EN
    logic        clr;
    logic [15:0] edge_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        bit rise;
    } exp_t;

    exp_t exp_q[$];

    pad_in_filter #(
        .CntWidth(8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pad_in_i       (pad),
        .filter_en_i    (en),
        .filter_thresh_i(thresh),
`ifdef PAD_IN_FILTER_EDGE_CNT_EN
        .edge_cnt_clr_i (clr),
        .edge_cnt_o     (edge_cnt),
`endif
        .data_o         (data_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rise_o || fall_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d rise=%0b fall=%0b, required no pulse",
                         cyc, rise_o, fall_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || rise_o != e.rise || fall_o != !e.rise || data_o != e.rise)
                begin
                    errors++;
                    $display("FAIL edge_event: got cycle %0d rise=%0b fall=%0b data=%0b, required cycle %0d rise=%0b fall=%0b data=%0b",
                             cyc, rise_o, fall_o, data_o, e.cyc, e.rise, !e.rise, e.rise);
                end
            end
        end
    end

    task automatic push_exp(input int at, input bit r);
        exp_t e;
        e.cyc  = at;
        e.rise = r;
        exp_q.push_back(e);
    endtask

    // Drive pad just after a rising edge; c returns that edge's cycle number.
    task automatic drive_pad(input logic v, output int c);
        @(posedge clk);
        #1;
        pad = v;
        c   = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    initial begin
        int c;
        int r;
        rst_n  = 1'b0;
        pad    = 1'b0;
        en     = 1'b0;
        thresh = 8'd4;
`ifdef PAD_IN_FILTER_EDGE_CNT_EN
        clr    = 1'b0;
`endif
        wait_cycles(3);
        check_bit("reset_data", data_o, 1'b0);
        check_bit("reset_rise", rise_o, 1'b0);
        check_bit("reset_fall", fall_o, 1'b0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Bypass: 3-edge latency.
        en = 1'b0;
        drive_pad(1'b1, c);
        push_exp(c + 3, 1'b1);
        wait_cycles(6);
        check_bit("bypass_data_hi", data_o, 1'b1);
        drive_pad(1'b0, c);
        push_exp(c + 3, 1'b0);
        wait_cycles(6);

        // Debounce accept, threshold 4: 4 cycles after sync shows the new level.
        en     = 1'b1;
        thresh = 8'd4;
        drive_pad(1'b1, c);
        push_exp(c + 6, 1'b1);
        wait_cycles(10);
        drive_pad(1'b0, c);
        push_exp(c + 6, 1'b0);
        wait_cycles(10);

        // Glitch of 3 cycles is rejected.
        drive_pad(1'b1, c);
        wait_cycles(3);
        pad = 1'b0;
        wait_cycles(10);
        check_bit("glitch_data", data_o, 1'b0);

        // Threshold 1 and 0 behave like bypass.
        thresh = 8'd1;
        drive_pad(1'b1, c);
        push_exp(c + 3, 1'b1);
        wait_cycles(6);
        thresh = 8'd0;
        drive_pad(1'b0, c);
        push_exp(c + 3, 1'b0);
        wait_cycles(6);

        // Maximum threshold, pad held 300 cycles: exactly one accept.
        thresh = 8'd255;
        drive_pad(1'b1, c);
        push_exp(c + 257, 1'b1);
        wait_cycles(300);
        check_bit("sat_data_hi", data_o, 1'b1);

        // Lower threshold to 10 once the count reaches 20: accept on the next edge.
        drive_pad(1'b0, c);
        wait_cycles(22);
        thresh = 8'd10;
        push_exp(c + 23, 1'b0);
        wait_cycles(10);
        check_bit("thresh_drop_data", data_o, 1'b0);

        // Disable mid-qualify: data follows sync on the next edge.
        thresh = 8'd8;
        drive_pad(1'b1, c);
        wait_cycles(5);
        en = 1'b0;
        push_exp(c + 6, 1'b1);
        wait_cycles(6);
        check_bit("disable_data", data_o, 1'b1);

        // Reset mid-qualify discards progress.
        drive_pad(1'b0, c);
        push_exp(c + 3, 1'b0);
        wait_cycles(6);
        en     = 1'b1;
        thresh = 8'd8;
        drive_pad(1'b1, c);
        wait_cycles(7);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_data", data_o, 1'b0);
        check_bit("midrst_rise", rise_o, 1'b0);
        check_bit("midrst_fall", fall_o, 1'b0);
        wait_cycles(3);
        rst_n = 1'b1;
        r     = cyc;
        push_exp(r + 10, 1'b1);
        wait_cycles(15);
        check_bit("postrst_data", data_o, 1'b1);

`ifdef PAD_IN_FILTER_EDGE_CNT_EN
        // Edge counter: clear, count 3 rise + 3 fall, then clear against a pulse.
        en  = 1'b0;
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        drive_pad(1'b0, c);
        push_exp(c + 3, 1'b0);
        wait_cycles(6);
        for (int i = 0; i < 3; i++) begin
            drive_pad(1'b1, c);
            push_exp(c + 3, 1'b1);
            wait_cycles(5);
            drive_pad(1'b0, c);
            push_exp(c + 3, 1'b0);
            wait_cycles(5);
        end
        checks++;
        if (edge_cnt !== 16'd7) begin
            errors++;
            $display("FAIL edge_cnt_seven: got %0d, required 7", edge_cnt);
        end
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pad(1'b1, c);
            push_exp(c + 3, 1'b1);
            wait_cycles(5);
            drive_pad(1'b0, c);
            push_exp(c + 3, 1'b0);
            wait_cycles(5);
        end
        checks++;
        if (edge_cnt !== 16'd6) begin
            errors++;
            $display("FAIL edge_cnt_six: got %0d, required 6", edge_cnt);
        end
        drive_pad(1'b1, c);
        push_exp(c + 3, 1'b1);
        wait_cycles(3);
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        checks++;
        if (edge_cnt !== 16'd0) begin
            errors++;
            $display("FAIL edge_cnt_clr: got %0d, required 0", edge_cnt);
        end
        wait_cycles(4);
`endif

        wait_cycles(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected events never seen, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
